// File: rtl/dist_pkg.sv
// dist_pkg: shared helpers for the distance-zone classifier.
//   zw(n)            width of a zone index able to hold 0..n (n = out-of-range code)
//   thresh_slice()   extracts threshold T[idx] from a packed threshold vector
//   DIST_THRESH_DEF  default 4-entry threshold vector (CW = 20, N_ZONES = 3)
package dist_pkg;

  // Packed threshold vectors are widened to this size before slicing, so
  // one helper serves every CW <= 32 and N_ZONES <= 8.
  localparam int DIST_MAX_CW = 32;
  localparam int DIST_MAX_T  = 9;
  localparam int DIST_VEC_W  = DIST_MAX_CW * DIST_MAX_T;

  localparam logic [79:0] DIST_THRESH_DEF =
    {20'd60000, 20'd30000, 20'd15000, 20'd1000};

  function automatic int zw(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [DIST_MAX_CW-1:0] thresh_slice(
    input logic [DIST_VEC_W-1:0] vec,
    input int                    cw,
    input int                    idx
  );
    logic [DIST_VEC_W-1:0]  sh;
    logic [DIST_MAX_CW-1:0] mask;
    sh   = vec >> (idx * cw);
    mask = {DIST_MAX_CW{1'b1}} >> (DIST_MAX_CW - cw);
    return sh[DIST_MAX_CW-1:0] & mask;
  endfunction

endpackage

// File: rtl/dist_zone_clasif.sv
// dist_zone_clasif: combinational echo-count to raw-zone classifier.
//   count  in   CW         echo width in clk cycles
//   zone   in   zw(N)      currently committed zone (used only for hysteresis)
//   raw    out  zw(N)      raw zone: i when T[i] <= count < T[i+1], else N_ZONES
// Optional feature macro: DIST_HYST_EN. When defined, a sample that falls
// within HYST counts of the committed in-range zone's band keeps that zone.
module dist_zone_clasif
  import dist_pkg::*;
#(
  parameter int                          CW      = 20,
  parameter int                          N_ZONES = 3,
  parameter logic [(N_ZONES+1)*CW-1:0]   THRESH  = DIST_THRESH_DEF,
  parameter int                          HYST    = 500
) (
  input  logic [CW-1:0]              count,
  input  logic [zw(N_ZONES)-1:0]     zone,
  output logic [zw(N_ZONES)-1:0]     raw
);

  localparam int             ZW  = zw(N_ZONES);
  localparam logic [ZW-1:0]  OOR = ZW'(N_ZONES);

  genvar gi;

  logic [N_ZONES-1:0] in_band;
  logic [ZW-1:0]      plain;

  generate
    for (gi = 0; gi < N_ZONES; gi++) begin : g_band
      localparam logic [CW-1:0] T_LO = CW'(thresh_slice(DIST_VEC_W'(THRESH), CW, gi));
      localparam logic [CW-1:0] T_HI = CW'(thresh_slice(DIST_VEC_W'(THRESH), CW, gi + 1));
      assign in_band[gi] = (count >= T_LO) && (count < T_HI);
    end
  endgenerate

  // Thresholds are strictly ascending, so at most one band matches.
  always_comb begin
    plain = OOR;
    for (int i = 0; i < N_ZONES; i++) begin
      if (in_band[i]) plain = ZW'(i);
    end
  end

`ifdef DIST_HYST_EN
  logic [N_ZONES-1:0] hyst_band;
  logic               hold;

  generate
    for (gi = 0; gi < N_ZONES; gi++) begin : g_hyst
      localparam logic [CW-1:0] T_LO   = CW'(thresh_slice(DIST_VEC_W'(THRESH), CW, gi));
      localparam logic [CW-1:0] T_HI   = CW'(thresh_slice(DIST_VEC_W'(THRESH), CW, gi + 1));
      localparam logic [CW:0]   HYST_W = (CW+1)'(HYST);
      // Widened bounds computed one bit wider so they clamp instead of wrapping.
      localparam logic [CW:0]   HI_SUM = {1'b0, T_HI} + HYST_W;
      localparam logic [CW-1:0] LO_W   = ({1'b0, T_LO} >= HYST_W) ? CW'({1'b0, T_LO} - HYST_W) : '0;
      localparam logic [CW-1:0] HI_W   = HI_SUM[CW] ? '1 : HI_SUM[CW-1:0];
      assign hyst_band[gi] = (count >= LO_W) && (count < HI_W);
    end
  endgenerate

  // Widening applies only around an in-range committed zone.
  always_comb begin
    hold = 1'b0;
    for (int i = 0; i < N_ZONES; i++) begin
      if ((zone == ZW'(i)) && hyst_band[i]) hold = 1'b1;
    end
  end

  assign raw = hold ? zone : plain;
`else
  logic        unused_zone;
  logic [31:0] unused_hyst;
  assign unused_zone = ^zone;
  assign unused_hyst = HYST;
  assign raw         = plain;
`endif

endmodule

// File: rtl/distancia_zonas.sv
// distancia_zonas: debounced distance-zone classifier with echo watchdog.
//   clk          in   1          system clock
//   rst          in   1          synchronous active-high reset
//   count        in   CW         echo width, sampled when count_valid = 1
//   count_valid  in   1          one-cycle strobe for a new measurement
//   zone_onehot  out  N_ZONES+1  committed zone, one-hot (MSB = out-of-range)
//   zone_idx     out  zw(N)      committed zone index (N_ZONES = out-of-range)
//   zone_changed out  1          one-cycle pulse with each new committed zone
//   timeout      out  1          high while the echo watchdog has expired
// Optional feature macro: DIST_HYST_EN (boundary hysteresis in the classifier).
module distancia_zonas
  import dist_pkg::*;
#(
  parameter int                          CW      = 20,
  parameter int                          N_ZONES = 3,
  parameter logic [(N_ZONES+1)*CW-1:0]   THRESH  = DIST_THRESH_DEF,
  parameter int                          STABLE  = 3,
  parameter int                          HYST    = 500,
  parameter int                          TIMEOUT = 3_000_000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CW-1:0]              count,
  input  logic                       count_valid,
  output logic [N_ZONES:0]           zone_onehot,
  output logic [zw(N_ZONES)-1:0]     zone_idx,
  output logic                       zone_changed,
  output logic                       timeout
);

  localparam int              ZW      = zw(N_ZONES);
  localparam int              RW      = $clog2(STABLE + 1);
  localparam int              WDW     = $clog2(TIMEOUT + 1);
  localparam logic [ZW-1:0]   OOR     = ZW'(N_ZONES);
  localparam logic [RW-1:0]   RUN_MAX = RW'(STABLE);
  localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);

  logic [ZW-1:0]  raw_zone;
  logic [ZW-1:0]  cand_reg;
  logic           s1v_reg;
  logic [ZW-1:0]  commit_reg, commit_next;
  logic [ZW-1:0]  pend_reg,   pend_next;
  logic [RW-1:0]  run_reg,    run_next;
  logic           chg_reg,    chg_next;
  logic [WDW-1:0] wd_reg;
  logic           timeout_reg;
  logic           expire;

  dist_zone_clasif #(
    .CW      (CW),
    .N_ZONES (N_ZONES),
    .THRESH  (THRESH),
    .HYST    (HYST)
  ) u_clasif (
    .count (count),
    .zone  (commit_reg),
    .raw   (raw_zone)
  );

  // Stage 1: capture the raw zone of each strobed sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_reg <= '0;
      s1v_reg  <= 1'b0;
    end else begin
      s1v_reg <= count_valid;
      if (count_valid) cand_reg <= raw_zone;
    end
  end

  // Watchdog. A strobe in the would-be expiry cycle wins, so expiry is
  // qualified with !count_valid. Once expired the counter holds.
  assign expire = !count_valid && !timeout_reg && (wd_reg == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else if (count_valid) begin
      wd_reg      <= '0;
      timeout_reg <= 1'b0;
    end else if (!timeout_reg) begin
      wd_reg <= wd_reg + 1'b1;
      if (expire) timeout_reg <= 1'b1;
    end
  end

  // Stage 2: consecutive-sample debounce; expiry overrides it.
  always_comb begin
    commit_next = commit_reg;
    pend_next   = pend_reg;
    run_next    = run_reg;
    chg_next    = 1'b0;
    if (expire) begin
      commit_next = OOR;
      pend_next   = '0;
      run_next    = '0;
      chg_next    = (commit_reg != OOR);
    end else if (s1v_reg) begin
      if (cand_reg == commit_reg) begin
        run_next = '0;
      end else if (cand_reg == pend_reg) begin
        run_next = (run_reg == RUN_MAX) ? run_reg : run_reg + 1'b1;
      end else begin
        pend_next = cand_reg;
        run_next  = RW'(1);
      end
      // Commit in the same edge the run length reaches STABLE.
      if ((run_next == RUN_MAX) && (pend_next != commit_reg)) begin
        commit_next = pend_next;
        chg_next    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      commit_reg <= OOR;
      pend_reg   <= '0;
      run_reg    <= '0;
      chg_reg    <= 1'b0;
    end else begin
      commit_reg <= commit_next;
      pend_reg   <= pend_next;
      run_reg    <= run_next;
      chg_reg    <= chg_next;
    end
  end

  assign zone_idx     = commit_reg;
  assign zone_onehot  = (N_ZONES+1)'(1) << commit_reg;
  assign zone_changed = chg_reg;
  assign timeout      = timeout_reg;

endmodule

// File: tb/tb_distancia_zonas.sv
// tb_distancia_zonas: self-checking bench for distancia_zonas (TIMEOUT = 100).
// A cycle-level behavioural model updated on each rising edge is compared
// with the DUT outputs on every falling edge; directed phases add literal
// expectations, then a randomized phase exercises strobes, idles and resets.
module tb_distancia_zonas;

  localparam int N   = 3;
  localparam int TO  = 100;
  localparam int STB = 3;
  localparam int HY  = 500;
  localparam int MAXC = (1 << 20) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] count = '0;
  logic        count_valid = 1'b0;
  logic [3:0]  zone_onehot;
  logic [1:0]  zone_idx;
  logic        zone_changed;
  logic        timeout;

  distancia_zonas #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .count        (count),
    .count_valid  (count_valid),
    .zone_onehot  (zone_onehot),
    .zone_idx     (zone_idx),
    .zone_changed (zone_changed),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  int thr [0:3] = '{1000, 15000, 30000, 60000};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Zone of a sample given the committed zone at the time it is strobed.
  function automatic int classify(input int c, input int committed);
`ifdef DIST_HYST_EN
    if (committed < N) begin
      int lo, hi;
      lo = (thr[committed] >= HY) ? thr[committed] - HY : 0;
      hi = thr[committed+1] + HY;
      if (hi > MAXC) hi = MAXC;
      if (c >= lo && c < hi) return committed;
    end
`endif
    for (int i = 0; i < N; i++)
      if (c >= thr[i] && c < thr[i+1]) return i;
    return N;
  endfunction

  // Behavioural model state.
  int m_commit = N, m_pend = 0, m_run = 0, m_idle = 0;
  int m_to = 0, m_chg = 0, m_s1v = 0, m_s1c = 0;
  bit started = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_commit = N; m_pend = 0; m_run = 0; m_idle = 0;
      m_to = 0; m_chg = 0; m_s1v = 0; m_s1c = 0;
    end else begin
      int  new_c;
      bit  new_v, expired;
      new_v   = count_valid;
      new_c   = classify(int'(count), m_commit);
      expired = 0;
      m_chg   = 0;
      if (new_v) begin
        m_idle = 0; m_to = 0;
      end else if (!m_to) begin
        m_idle++;
        if (m_idle == TO) begin m_to = 1; expired = 1; end
      end
      if (expired) begin
        m_chg    = (m_commit != N);
        m_commit = N; m_pend = 0; m_run = 0;
      end else if (m_s1v) begin
        if (m_s1c == m_commit) m_run = 0;
        else if (m_s1c == m_pend) m_run = (m_run < STB) ? m_run + 1 : STB;
        else begin m_pend = m_s1c; m_run = 1; end
        if (m_run == STB && m_pend != m_commit) begin
          m_commit = m_pend; m_chg = 1;
        end
      end
      m_s1v = new_v;
      m_s1c = new_c;
    end
    started = 1;
  end

  // Compare process: every cycle after the first edge.
  always @(negedge clk) begin
    if (started) begin
      check("zone_idx",     {30'd0, zone_idx},     m_commit);
      check("zone_onehot",  {28'd0, zone_onehot},  32'd1 << m_commit);
      check("zone_changed", {31'd0, zone_changed}, m_chg);
      check("timeout",      {31'd0, timeout},      m_to);
    end
  end

  // Driver helpers; all called while sitting on a falling edge.
  task automatic strobe(input int v);
    count_valid = 1'b1;
    count       = v[19:0];
    @(negedge clk);
    count_valid = 1'b0;
    count       = 20'($urandom);
  endtask

  task automatic strobes(input int v, input int n);
    for (int i = 0; i < n; i++) strobe(v);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    gap(2);
    rst = 1'b0;
  endtask

  int exp_hold;

  initial begin
    gap(2);
    rst = 1'b0;

    // Reset then idle: expiry on the 100th edge, no change pulse.
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      check("idle_timeout", {31'd0, timeout}, (i == TO) ? 1 : 0);
      check("idle_changed", {31'd0, zone_changed}, 0);
      if (i == TO) check("idle_idx", {30'd0, zone_idx}, 3);
    end

    // Two strobes do not commit.
    do_reset();
    strobe(20000); gap(1); strobe(20000);
    gap(4);
    check("two_strobes_idx", {30'd0, zone_idx}, 3);

    // Three strobes commit zone 1 two cycles after the third.
    do_reset();
    strobe(20000); gap(1); strobe(20000); gap(1); strobe(20000);
    check("commit_early_idx", {30'd0, zone_idx}, 3);
    @(negedge clk);
    check("commit_idx",     {30'd0, zone_idx}, 1);
    check("commit_onehot",  {28'd0, zone_onehot}, 4'b0010);
    check("commit_changed", {31'd0, zone_changed}, 1);
    @(negedge clk);
    check("commit_pulse_end", {31'd0, zone_changed}, 0);

    // Alternating samples never commit.
    for (int i = 0; i < 8; i++) strobe((i % 2 == 0) ? 8000 : 20000);
    gap(3);
    check("alternate_idx", {30'd0, zone_idx}, 1);

    // Hysteresis around the zone 1 lower boundary.
`ifdef DIST_HYST_EN
    exp_hold = 1;
`else
    exp_hold = 0;
`endif
    strobes(14700, 3); gap(3);
    check("hyst_14700_idx", {30'd0, zone_idx}, exp_hold);
    strobes(14400, 3); gap(3);
    check("hyst_14400_idx", {30'd0, zone_idx}, 0);

    // Boundaries.
    do_reset(); strobes(1000, 3); gap(3);
    check("bnd_1000", {30'd0, zone_idx}, 0);
    strobes(999, 3); gap(3);
`ifdef DIST_HYST_EN
    check("bnd_999_from0", {30'd0, zone_idx}, 0);
`else
    check("bnd_999_from0", {30'd0, zone_idx}, 3);
`endif
    do_reset(); strobes(999, 3); gap(3);
    check("bnd_999", {30'd0, zone_idx}, 3);
    do_reset(); strobes(59999, 3); gap(3);
    check("bnd_59999", {30'd0, zone_idx}, 2);
    strobes(60000, 3); gap(3);
`ifdef DIST_HYST_EN
    check("bnd_60000_from2", {30'd0, zone_idx}, 2);
`else
    check("bnd_60000_from2", {30'd0, zone_idx}, 3);
`endif
    do_reset(); strobes(60000, 3); gap(3);
    check("bnd_60000", {30'd0, zone_idx}, 3);

    // Reset between 2nd and 3rd strobe discards the run.
    do_reset();
    strobes(40000, 2);
    do_reset();
    check("rst_mid_idx", {30'd0, zone_idx}, 3);
    strobe(40000); gap(4);
    check("rst_mid_after", {30'd0, zone_idx}, 3);

    // Watchdog expiry from an in-range zone, then cleared by a strobe.
    do_reset();
    strobes(40000, 3);
    gap(TO);
    check("wd_timeout", {31'd0, timeout}, 1);
    check("wd_idx",     {30'd0, zone_idx}, 3);
    strobe(40000);
    check("wd_cleared", {31'd0, timeout}, 0);

    // Randomized phase.
    for (int g = 0; g < 400; g++) begin
      int v, r, sel;
      sel = $urandom_range(0, 9);
      if (sel == 0) v = $urandom_range(0, MAXC);
      else begin
        int d [0:8] = '{-501, -500, -499, -1, 0, 1, 499, 500, 501};
        v = thr[$urandom_range(0, 3)] + d[$urandom_range(0, 8)];
        if (sel >= 7) v = thr[$urandom_range(0, 2)] + $urandom_range(600, 14000);
      end
      r = $urandom_range(1, 4);
      for (int k = 0; k < r; k++) begin
        strobe(v);
        gap($urandom_range(0, 2));
      end
      if ($urandom_range(0, 39) == 0) gap($urandom_range(TO - 2, TO + 5));
      if ($urandom_range(0, 59) == 0) do_reset();
    end

    gap(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
